// File: rtl/prog_instr_mem.sv
// Instruction memory with an integrated serial-byte loader.
// A framed byte stream (length, little-endian words, XOR checksum) fills the array; the fetch port is registered.
`timescale 1ns/1ps

module prog_instr_mem #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] instruction,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [LEN_W-1:0]  words_loaded
);

    localparam int BPW   = DATA_W / 8;
    localparam int OFF_W = $clog2(BPW);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CSUM
    } state_t;

    state_t             state;
    logic [7:0]         len_lo;
    logic [LEN_W-1:0]   len;
    logic [CNT_W-1:0]   byte_cnt;
    logic [DATA_W-1:0]  word_sr;
    logic [7:0]         csum;

    logic [DATA_W-1:0]  mem [DEPTH];

    logic [15:0]        hdr_len;
    logic               hdr_too_long;
    logic [DATA_W-1:0]  word_next;
    logic               last_byte;
    logic               wr_en;
    logic [IDX_W-1:0]   wr_idx;
    logic [LEN_W-1:0]   words_next;
    logic [ADDR_W-1:0]  rd_idx;
    logic               rd_in_range;

    assign hdr_len      = {rx_byte, len_lo};
    assign hdr_too_long = {16'd0, hdr_len} > 32'(DEPTH);

    // Bytes enter at the top and drift down, so the first byte of a word ends in bits [7:0].
    assign word_next  = (word_sr >> 8) | (DATA_W'(rx_byte) << (DATA_W - 8));
    assign last_byte  = (byte_cnt == CNT_W'(BPW - 1));
    assign wr_en      = (state == S_DATA) && rx_valid && last_byte;
    assign wr_idx     = words_loaded[IDX_W-1:0];
    assign words_next = words_loaded + LEN_W'(1);

    assign rd_idx      = rd_addr >> OFF_W;
    assign rd_in_range = rd_idx < ADDR_W'(DEPTH);

    // NOTE: the array has no reset so it maps onto block RAM; its contents survive rst_n.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= word_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instruction <= '0;
        end else if (busy || !rd_in_range) begin
            instruction <= '0;
        end else begin
            instruction <= mem[rd_idx[IDX_W-1:0]];
        end
    end

    // NOTE: every register here uses <= so all branches see the pre-edge values of state and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
            len_lo       <= '0;
            len          <= '0;
            byte_cnt     <= '0;
            word_sr      <= '0;
            csum         <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state        <= S_LEN_LO;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        words_loaded <= '0;
                        byte_cnt     <= '0;
                        word_sr      <= '0;
                        csum         <= '0;
                    end
                end

                S_LEN_LO: begin
                    if (rx_valid) begin
                        len_lo <= rx_byte;
                        state  <= S_LEN_HI;
                    end
                end

                S_LEN_HI: begin
                    if (rx_valid) begin
                        len <= LEN_W'(hdr_len);
                        if (hdr_too_long) begin
                            error <= 1'b1;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else if (hdr_len == 16'd0) begin
                            state <= S_CSUM;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end

                S_DATA: begin
                    if (rx_valid) begin
                        csum    <= csum ^ rx_byte;
                        word_sr <= word_next;
                        if (last_byte) begin
                            byte_cnt     <= '0;
                            words_loaded <= words_next;
                            if (words_next == len) begin
                                state <= S_CSUM;
                            end
                        end else begin
                            byte_cnt <= byte_cnt + CNT_W'(1);
                        end
                    end
                end

                S_CSUM: begin
                    if (rx_valid) begin
                        error <= (rx_byte != csum);
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_instr_mem.sv
// Self-checking bench for prog_instr_mem: framed loads built from the frame rules, checked against an array model.
`timescale 1ns/1ps

module tb_prog_instr_mem;

    localparam int DEPTH = 1024;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic [31:0] rd_addr;
    logic [31:0] instruction;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    int checks;
    int failures;

    logic [31:0] model_mem [DEPTH];
    logic [31:0] word_q [$];
    logic [7:0]  frame_q [$];

    prog_instr_mem #(
        .DATA_W(32),
        .DEPTH (DEPTH),
        .ADDR_W(32),
        .LEN_W (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .rx_valid    (rx_valid),
        .rx_byte     (rx_byte),
        .rd_addr     (rd_addr),
        .instruction (instruction),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .words_loaded(words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Checksum is the XOR of every data byte of every word; header bytes excluded.
    function automatic logic [7:0] data_xor();
        logic [7:0] x;
        x = 8'h00;
        foreach (word_q[i]) begin
            x = x ^ word_q[i][7:0] ^ word_q[i][15:8] ^ word_q[i][23:16] ^ word_q[i][31:24];
        end
        return x;
    endfunction

    task automatic build_frame(input int len, input logic [7:0] csum_flip);
        logic [15:0] l;
        l = 16'(len);
        frame_q = {};
        frame_q.push_back(l[7:0]);
        frame_q.push_back(l[15:8]);
        foreach (word_q[i]) begin
            for (int b = 0; b < 4; b++) frame_q.push_back(8'(word_q[i] >> (8 * b)));
        end
        frame_q.push_back(data_xor() ^ csum_flip);
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int gap;
        @(negedge clk);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_byte  = 8'($urandom);
        gap = $urandom_range(0, max_gap);
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_range(input int from, input int to, input int max_gap);
        for (int i = from; i <= to; i++) send_byte(frame_q[i], max_gap);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic commit(input int n);
        for (int i = 0; i < n; i++) model_mem[i] = word_q[i];
    endtask

    task automatic check_read(input string tag, input logic [31:0] addr);
        logic [31:0] exp;
        int idx;
        idx = int'(addr >> 2);
        exp = (addr >= 32'(DEPTH * 4)) ? 32'h0 : model_mem[idx];
        @(negedge clk);
        rd_addr = addr;
        @(negedge clk);
        check(tag, instruction, exp);
    endtask

    task automatic check_status(input string tag, input logic exp_done, input logic exp_err,
                                input int exp_words);
        check({tag, "_busy"}, 32'(busy), 32'(0));
        check({tag, "_done"}, 32'(done), 32'(exp_done));
        check({tag, "_error"}, 32'(error), 32'(exp_err));
        check({tag, "_words"}, 32'(words_loaded), 32'(exp_words));
    endtask

    task automatic full_load(input string tag, input logic [7:0] flip, input int max_gap);
        build_frame(word_q.size(), flip);
        pulse_start();
        send_range(0, frame_q.size() - 1, max_gap);
        commit(word_q.size());
        check_status(tag, 1'b1, flip != 8'h00, word_q.size());
    endtask

    initial begin
        int idx;
        logic [31:0] saved_w1;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        rd_addr  = 32'h0;

        #12;
        check("rst_instruction", instruction, 32'h0);
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_error", 32'(error), 32'(0));
        check("rst_words", 32'(words_loaded), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Two-word program with a correct checksum, then readback.
        word_q = {32'h0000_0013, 32'h0010_0093};
        full_load("t1", 8'h00, 2);
        check_read("t1_rd0", 32'd0);
        check_read("t1_rd4", 32'd4);

        // Same frame with a corrupted checksum: error but memory kept.
        full_load("t2", 8'h01, 1);
        check_read("t2_rd4", 32'd4);

        // Oversized header aborts after the second byte; later bytes are ignored in IDLE.
        pulse_start();
        frame_q = {8'h01, 8'h04};
        send_range(0, 1, 0);
        check_status("t3", 1'b1, 1'b1, 0);
        send_byte(8'h55, 0);
        check("t3_idle_done", 32'(done), 32'(1));
        check_read("t3_rd0", 32'd0);

        // Reads are blanked while loading; a second start mid-frame is ignored.
        word_q = {};
        for (int i = 0; i < 3; i++) word_q.push_back($urandom);
        build_frame(3, 8'h00);
        pulse_start();
        send_range(0, 3, 1);
        @(negedge clk);
        rd_addr = 32'd0;
        @(negedge clk);
        check("t4_rd_busy", instruction, 32'h0);
        check("t4_busy", 32'(busy), 32'(1));
        pulse_start();
        send_range(4, frame_q.size() - 1, 1);
        commit(3);
        check_status("t4", 1'b1, 1'b0, 3);
        for (int i = 0; i < 3; i++) check_read("t4_rd", 32'(i * 4 + $urandom_range(0, 3)));

        // Reset after five data bytes: first word lands, the partial second word is dropped.
        saved_w1 = model_mem[1];
        word_q = {$urandom, $urandom};
        build_frame(2, 8'h00);
        pulse_start();
        send_range(0, 6, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_busy", 32'(busy), 32'(0));
        check("t5_rst_done", 32'(done), 32'(0));
        check("t5_rst_instr", instruction, 32'h0);
        commit(1);
        @(negedge clk);
        rst_n = 1'b1;
        check_read("t5_partial_rd0", 32'd0);
        check_read("t5_keep_rd4", 32'd4);
        check("t5_model_w1", model_mem[1], saved_w1);
        word_q = {32'hDEAD_BEEF};
        full_load("t5", 8'h00, 2);
        check_read("t5_rd0", 32'd0);

        // Empty program: header then checksum of zero.
        word_q = {};
        full_load("len0", 8'h00, 0);

        // Maximum-length program fills every word.
        word_q = {};
        for (int i = 0; i < DEPTH; i++) word_q.push_back($urandom);
        full_load("full", 8'h00, 0);
        check_read("full_rd_last", 32'd4095);
        check_read("full_rd_oob", 32'd4096);
        check_read("full_rd_far", 32'hFFFF_FFFC);
        check_read("full_rd6", 32'd6);
        for (int i = 0; i < 12; i++) begin
            idx = $urandom_range(0, DEPTH - 1);
            check_read("full_rd_rand", 32'(idx * 4 + $urandom_range(0, 3)));
        end

        // Random short programs with random checksum faults.
        for (int n = 0; n < 4; n++) begin
            word_q = {};
            for (int i = 0; i < $urandom_range(1, 12); i++) word_q.push_back($urandom);
            full_load("rand", (n % 2 == 1) ? 8'(1 << $urandom_range(0, 7)) : 8'h00, 2);
            check_read("rand_rd", 32'($urandom_range(0, word_q.size() - 1) * 4));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
